// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store unit with byte/half extraction and SB/SH read-modify-write
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, WRITE} state_t;

  state_t      state;
  state_t      state_nx;

  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;

  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  // Classify the incoming request: illegal width code, misalignment, or index past the memory
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_we) begin
      illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    end else begin
      illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    end
    case (funct3)
      3'b001, 3'b101: misaligned = addr[0];
      3'b010:         misaligned = (addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
    out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    req_bad      = illegal | misaligned | out_of_range;
  end

  // Load lane extraction and store lane merge, both working on the latched request
  always_comb begin
    shifted = mem_rd >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = mem_rd;
    endcase
    if (f3_q == 3'b001) begin
      lane_mask = 32'h0000FFFF << {addr_q[1], 4'b0000};
      lane_data = {2{wdata_q[15:0]}};
    end else begin
      lane_mask = 32'h000000FF << {addr_q[1:0], 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end
    merged = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: SW writes directly, SB/SH need a read first, rejected requests stay idle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid && !req_bad) begin
          if (!req_we) begin
            state_nx = LOAD;
          end else if (funct3 == 3'b010) begin
            state_nx = WRITE;
          end else begin
            state_nx = RMW_RD;
          end
        end
      end
      LOAD:    state_nx = IDLE;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side outputs; a reset during WRITE blocks the write in that same cycle
  always_comb begin
    busy   = (state != IDLE);
    mem_a  = busy ? {2'b00, addr_q[31:2]} : 32'h0;
    mem_we = (state == WRITE) && !rst;
    mem_wd = 32'h0;
    if (state == WRITE) begin
      mem_wd = (f3_q == 3'b010) ? wdata_q : merge_q;
    end
  end

  // Request latch, load result, merge buffer and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              f3_q    <= funct3;
              addr_q  <= addr;
              wdata_q <= wdata;
            end
          end
        end
        LOAD: begin
          rdata       <= load_val;
          rdata_valid <= 1'b1;
        end
        RMW_RD: begin
          merge_q <= merged;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = 10'd0;
  logic [31:0] bd_data = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int we_count = 0;
  int both_count = 0;
  logic [31:0] last_rdata = 32'h0;

  lsu_mem_ctrl #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
    .err(err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:0]];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_we) begin
      mem[mem_a[9:0]] <= mem_wd;
    end
    if (mem_we) we_count <= we_count + 1;
  end

  always @(negedge clk) begin
    if (err && rdata_valid) both_count <= both_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; funct3 = f3; addr = a; wdata = 32'h0;
    step();
    req_valid = 1'b0;
    chk({tag, ".busy1"}, {31'h0, busy}, 32'h1);
    chk({tag, ".we1"}, {31'h0, mem_we}, 32'h0);
    chk({tag, ".rv1"}, {31'h0, rdata_valid}, 32'h0);
    step();
    chk({tag, ".rv2"}, {31'h0, rdata_valid}, 32'h1);
    chk({tag, ".rdata"}, rdata, exp);
    chk({tag, ".busy2"}, {31'h0, busy}, 32'h0);
    chk({tag, ".err2"}, {31'h0, err}, 32'h0);
    last_rdata = exp;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_word);
    req_valid = 1'b1; req_we = 1'b1; funct3 = f3; addr = a; wdata = wd;
    step();
    req_valid = 1'b0;
    chk({tag, ".busy1"}, {31'h0, busy}, 32'h1);
    if (f3 == 3'b010) begin
      chk({tag, ".we1"}, {31'h0, mem_we}, 32'h1);
      chk({tag, ".wd1"}, mem_wd, exp_word);
      chk({tag, ".a1"}, mem_a, {2'b00, a[31:2]});
    end else begin
      chk({tag, ".we1"}, {31'h0, mem_we}, 32'h0);
      step();
      chk({tag, ".busy2"}, {31'h0, busy}, 32'h1);
      chk({tag, ".we2"}, {31'h0, mem_we}, 32'h1);
      chk({tag, ".wd2"}, mem_wd, exp_word);
      chk({tag, ".a2"}, mem_a, {2'b00, a[31:2]});
    end
    step();
    chk({tag, ".busy_end"}, {31'h0, busy}, 32'h0);
    chk({tag, ".we_end"}, {31'h0, mem_we}, 32'h0);
  endtask

  task automatic do_reject(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    chk({tag, ".err1"}, {31'h0, err}, 32'h1);
    chk({tag, ".busy1"}, {31'h0, busy}, 32'h0);
    chk({tag, ".we1"}, {31'h0, mem_we}, 32'h0);
    chk({tag, ".rv1"}, {31'h0, rdata_valid}, 32'h0);
    step();
    chk({tag, ".err2"}, {31'h0, err}, 32'h0);
    chk({tag, ".busy2"}, {31'h0, busy}, 32'h0);
    chk({tag, ".rdata"}, rdata, last_rdata);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // reset with backdoor preload of word 7 and word 1023
    rst = 1'b1;
    bd_we = 1'b1; bd_idx = 10'd7; bd_data = 32'h00F0F000;
    step();
    bd_idx = 10'd1023; bd_data = 32'h13579BDF;
    step();
    bd_we = 1'b0;
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.rv", {31'h0, rdata_valid}, 32'h0);
    chk("rst.err", {31'h0, err}, 32'h0);
    chk("rst.we", {31'h0, mem_we}, 32'h0);
    chk("rst.a", mem_a, 32'h0);
    chk("rst.wd", mem_wd, 32'h0);
    rst = 1'b0;
    step();

    // loads from word 7
    do_load("lw1c", 3'b010, 32'h1C, 32'h00F0F000);
    do_load("lb1d", 3'b000, 32'h1D, 32'hFFFFFFF0);
    do_load("lbu1d", 3'b100, 32'h1D, 32'h000000F0);
    do_load("lh1c", 3'b001, 32'h1C, 32'hFFFFF000);
    do_load("lhu1e", 3'b101, 32'h1E, 32'h000000F0);

    // stores with read-modify-write
    do_store("sb1e", 3'b000, 32'h1E, 32'h123456AB, 32'h00ABF000);
    do_load("lw_after_sb", 3'b010, 32'h1C, 32'h00ABF000);
    do_store("sh1c", 3'b001, 32'h1C, 32'h0000BEEF, 32'h00ABBEEF);
    do_load("lw_after_sh", 3'b010, 32'h1C, 32'h00ABBEEF);
    do_store("sw20", 3'b010, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb23", 3'b000, 32'h23, 32'hFFFFFFDE);
    do_load("lhu22", 3'b101, 32'h22, 32'h0000DEAD);

    // rejected requests
    do_reject("sh1d", 1'b1, 3'b001, 32'h1D);
    do_reject("lw1e", 1'b0, 3'b010, 32'h1E);
    do_reject("ld011", 1'b0, 3'b011, 32'h1C);
    do_reject("st100", 1'b1, 3'b100, 32'h1C);
    do_reject("lw1000", 1'b0, 3'b010, 32'h1000);
    do_load("lwffc", 3'b010, 32'hFFC, 32'h13579BDF);

    // request held while busy must be ignored
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h1C; wdata = 32'h00000055;
    step();
    funct3 = 3'b010; addr = 32'h20; wdata = 32'h00000000;
    chk("ign.busy1", {31'h0, busy}, 32'h1);
    step();
    chk("ign.we2", {31'h0, mem_we}, 32'h1);
    chk("ign.wd2", mem_wd, 32'h00ABBE55);
    req_valid = 1'b0;
    step();
    chk("ign.busy3", {31'h0, busy}, 32'h0);
    chk("ign.we3", {31'h0, mem_we}, 32'h0);
    do_load("ign.lw20", 3'b010, 32'h20, 32'hDEADBEEF);

    // reset during WRITE suppresses the write
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h1C; wdata = 32'h00000066;
    step();
    req_valid = 1'b0;
    chk("rw.busy1", {31'h0, busy}, 32'h1);
    step();
    rst = 1'b1;
    #1;
    chk("rw.we_in_rst", {31'h0, mem_we}, 32'h0);
    step();
    rst = 1'b0;
    chk("rw.busy", {31'h0, busy}, 32'h0);
    chk("rw.rdata", rdata, 32'h0);
    chk("rw.rv", {31'h0, rdata_valid}, 32'h0);
    chk("rw.err", {31'h0, err}, 32'h0);
    chk("rw.a", mem_a, 32'h0);
    chk("rw.wd", mem_wd, 32'h0);
    last_rdata = 32'h0;
    do_load("rw.lw1c", 3'b010, 32'h1C, 32'h00ABBE55);

    // global observations
    chk("we_total", we_count, 32'd4);
    chk("err_and_rv", both_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
